// File: rtl/perm_round_ctrl.sv
// rtl/perm_round_ctrl.sv - round controller for the iterative permutation state register bank
module perm_round_ctrl #(
  parameter int CNT_W      = 4,
  parameter int MAX_ROUNDS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] rounds_i,
  input  logic             hold_i,
  input  logic             abort_i,
  input  logic             done_ack_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             state_en_o,
  output logic             state_sel_o,
  output logic [CNT_W-1:0] round_idx_o,
  output logic             last_round_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_ROUNDS);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] w_n_nxt;
  logic [CNT_W-1:0] w_n_clamp;
  logic             w_last;

  assign w_n_clamp = (rounds_i > LP_MAX) ? LP_MAX : rounds_i;
  // Only meaningful in RUN, where N is guaranteed non-zero.
  assign w_last    = (r_cnt == (r_n - LP_ONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_n     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_n     <= w_n_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_n_nxt      = r_n;
    ready_o      = 1'b0;
    busy_o       = 1'b0;
    state_en_o   = 1'b0;
    state_sel_o  = 1'b0;
    round_idx_o  = '0;
    last_round_o = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o   = 1'b1;
        w_cnt_nxt = '0;
        if (start_i) begin
          w_n_nxt     = w_n_clamp;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        busy_o     = 1'b1;
        state_en_o = 1'b1;
        if (abort_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_n != '0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_RUN: begin
        busy_o       = 1'b1;
        state_sel_o  = 1'b1;
        state_en_o   = !hold_i;
        round_idx_o  = r_cnt;
        last_round_o = w_last;
        // Abort outranks both hold and round completion.
        if (abort_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (!hold_i) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + LP_ONE;
          end
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        if (abort_i || done_ack_i) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
